// File: rtl/tsc_mc_control.sv
// tsc_mc_control: multi-cycle control FSM for the TSC CPU (IF/ID/EX/MEM/WB/HALT).
// Latency: 2..5 cycles per instruction at zero memory wait; +1 per memory wait cycle.
// Backpressure: IF and LWD-MEM hold read_m until mem_ready; SWD-MEM holds write_m until ack_output.
// Ports: opcode/func come from the IR; mem_ready/ack_output are the memory handshake.
// Outputs are datapath mux selects, write strobes, memory requests, halted and num_inst.
module tsc_mc_control #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 mem_ready,
    input  logic                 ack_output,
    output logic                 read_m,
    output logic                 write_m,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 out_en,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] num_inst
);

    typedef enum logic [2:0] {
        S_RESET, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    state_t state, nextState;
    logic   retire;

    // Instruction class decode; only meaningful once the IR holds the new word.
    logic isRAlu, isImm, isMem, isBranch, isWwd, isJpr, isJrl, isHlt;

    assign isRAlu   = (opcode == OP_R) && (func <= 6'd7);
    assign isImm    = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
    assign isMem    = (opcode == OP_LWD) || (opcode == OP_SWD);
    assign isBranch = (opcode[3:2] == 2'b00);
    assign isWwd    = (opcode == OP_R) && (func == FN_WWD);
    assign isJpr    = (opcode == OP_R) && (func == FN_JPR);
    assign isJrl    = (opcode == OP_R) && (func == FN_JRL);
    assign isHlt    = (opcode == OP_R) && (func == FN_HLT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RESET;
            num_inst <= '0;
        end else begin
            state <= nextState;
            if (retire) begin
                num_inst <= num_inst + WORD_SIZE'(1);
            end
        end
    end

    always_comb begin
        nextState     = state;
        retire        = 1'b0;
        read_m        = 1'b0;
        write_m       = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        out_en        = 1'b0;
        halted        = 1'b0;

        case (state)
            S_RESET: nextState = S_IF;

            S_IF: begin
                read_m = 1'b1;
                // IR latch and PC+1 happen in the same cycle the fetch data arrives.
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'd1;
                    nextState = S_ID;
                end
            end

            S_ID: begin
                // Branch target (PC+1+imm) is always precomputed into ALUOut.
                alu_src_b = 2'd2;
                if (isRAlu || isImm || isMem || isBranch || isWwd) begin
                    nextState = S_EX;
                end else if (opcode == OP_JMP) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    retire    = 1'b1;
                    nextState = S_IF;
                end else if (isJpr) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd3;
                    retire    = 1'b1;
                    nextState = S_IF;
                end else if ((opcode == OP_JAL) || isJrl) begin
                    nextState = S_WB;
                end else if (isHlt) begin
                    retire    = 1'b1;
                    nextState = S_HALT;
                end else begin
                    // Unknown encodings retire as NOP.
                    retire    = 1'b1;
                    nextState = S_IF;
                end
            end

            S_EX: begin
                if (isRAlu) begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd1;
                    nextState = S_WB;
                end else if (isImm) begin
                    alu_src_a = 1'b1;
                    alu_src_b = (opcode == OP_ORI) ? 2'd3 : 2'd2;
                    alu_op    = 2'd3;
                    nextState = S_WB;
                end else if (isMem) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    nextState = S_MEM;
                end else if (isBranch) begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'd2;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'd1;
                    retire        = 1'b1;
                    nextState     = S_IF;
                end else if (isWwd) begin
                    out_en    = 1'b1;
                    retire    = 1'b1;
                    nextState = S_IF;
                end else begin
                    nextState = S_IF;
                end
            end

            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LWD) begin
                    read_m = 1'b1;
                    if (mem_ready) begin
                        nextState = S_WB;
                    end
                end else if (opcode == OP_SWD) begin
                    write_m = 1'b1;
                    if (ack_output) begin
                        retire    = 1'b1;
                        nextState = S_IF;
                    end
                end else begin
                    nextState = S_IF;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                nextState = S_IF;
                if (isRAlu) begin
                    reg_dst = 2'd1;
                end else if (opcode == OP_LWD) begin
                    mem_to_reg = 2'd1;
                end else if (opcode == OP_JAL) begin
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                end else if (isJrl) begin
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_src     = 2'd3;
                end
            end

            S_HALT: halted = 1'b1;

            default: nextState = S_RESET;
        endcase
    end

endmodule
